// File: rtl/apb_slave_pkg.sv
// Shared types and the address decoder for the APB register slave.
package apb_slave_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  localparam int unsigned REG_STRIDE = 4;
  // Index field is wide enough for up to 256 registers.
  localparam int unsigned IDX_W = 8;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             err;
    logic             is_write;
  } decode_t;

  function automatic decode_t decode(input logic [63:0] addr, input logic write,
                                     input logic [63:0] base, input int unsigned num_regs);
    decode_t     d;
    logic [63:0] offset;
    logic [63:0] word;
    // Addresses below base wrap to a huge offset and land in the out-of-range check.
    offset     = addr - base;
    word       = offset / 64'(REG_STRIDE);
    d.idx      = word[IDX_W-1:0];
    d.is_write = write;
    d.err      = (offset % 64'(REG_STRIDE) != 64'd0) ||
                 (word >= 64'(num_regs)) ||
                 (write && (word == 64'(num_regs - 1)));
    return d;
  endfunction

endpackage

// File: rtl/apb_slave_regs_reg_file.sv
// Register storage: RW registers with write strobes, plus the RO transfer counter in the top slot.
module apb_reg_file
  import apb_slave_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_commit,
  input  logic [IDX_W-1:0]           i_idx,
  input  logic [DATA_W-1:0]          i_wdata,
  input  logic                       i_write,
  input  logic                       i_count,
  output logic [NUM_REGS*DATA_W-1:0] o_regs,
  output logic [NUM_REGS-1:0]        o_wr_pulse
);

  logic [DATA_W-1:0] r_count;

  for (genvar gi = 0; gi < NUM_REGS - 1; gi++) begin : g_rw
    logic              w_hit;
    logic [DATA_W-1:0] r_data;
    logic              r_pulse;

    assign w_hit = i_commit && i_write && (i_idx == IDX_W'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_data  <= '0;
        r_pulse <= 1'b0;
      end else begin
        r_pulse <= w_hit;
        if (w_hit) r_data <= i_wdata;
      end
    end

    assign o_regs[gi*DATA_W +: DATA_W] = r_data;
    assign o_wr_pulse[gi]              = r_pulse;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_count <= '0;
    else if (i_count) r_count <= r_count + 1'b1;
  end

  assign o_regs[(NUM_REGS-1)*DATA_W +: DATA_W] = r_count;
  assign o_wr_pulse[NUM_REGS-1]                = 1'b0;

endmodule

// File: rtl/apb_slave_regs.sv
// APB3 completer with programmable wait states, PSLVERR on bad decode, and exported registers.
module apb_slave_regs
  import apb_slave_pkg::*;
#(
  parameter int unsigned      ADDR_W      = 32,
  parameter int unsigned      DATA_W      = 32,
  parameter int unsigned      NUM_REGS    = 8,
  parameter int unsigned      WAIT_STATES = 1,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic                       PCLK,
  input  logic                       PRESETn,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [ADDR_W-1:0]          PADDR,
  input  logic [DATA_W-1:0]          PWDATA,
  output logic [DATA_W-1:0]          PRDATA,
  output logic                       PREADY,
  output logic                       PSLVERR,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic [NUM_REGS-1:0]        wr_pulse_o
);

  state_e            r_state, r_state_next;
  logic [3:0]        r_cnt, r_cnt_next;
  decode_t           r_dec, r_dec_next;
  logic [DATA_W-1:0] r_wdata, r_wdata_next;
  logic [DATA_W-1:0] r_prdata, r_prdata_next;
  logic              r_pready, r_pready_next;
  logic              r_pslverr, r_pslverr_next;
  logic              w_commit;
  decode_t           w_dec;
  decode_t           w_rd_sel;
  logic [DATA_W-1:0] w_rd_data;
  logic [DATA_W-1:0] w_reg_arr [NUM_REGS];

  assign w_dec = decode(64'(PADDR), PWRITE, 64'(BASE_ADDR), NUM_REGS);

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_view
    assign w_reg_arr[gi] = regs_o[gi*DATA_W +: DATA_W];
  end

  // With zero wait states the read data is loaded on the setup edge, straight from the live decode.
  assign w_rd_sel = (r_state == IDLE) ? w_dec : r_dec;

  always_comb begin
    w_rd_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (!w_rd_sel.err && !w_rd_sel.is_write && (w_rd_sel.idx == IDX_W'(i))) w_rd_data = w_reg_arr[i];
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_dec     <= '0;
      r_wdata   <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      r_state   <= r_state_next;
      r_cnt     <= r_cnt_next;
      r_dec     <= r_dec_next;
      r_wdata   <= r_wdata_next;
      r_prdata  <= r_prdata_next;
      r_pready  <= r_pready_next;
      r_pslverr <= r_pslverr_next;
    end
  end

  always_comb begin
    r_state_next   = r_state;
    r_cnt_next     = r_cnt;
    r_dec_next     = r_dec;
    r_wdata_next   = r_wdata;
    r_prdata_next  = r_prdata;
    r_pready_next  = r_pready;
    r_pslverr_next = r_pslverr;
    w_commit       = 1'b0;
    case (r_state)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          r_dec_next   = w_dec;
          r_wdata_next = PWDATA;
          if (WAIT_STATES == 0) begin
            r_pready_next  = 1'b1;
            r_pslverr_next = w_dec.err;
            r_prdata_next  = w_rd_data;
            r_state_next   = DONE;
          end else begin
            r_cnt_next   = 4'(WAIT_STATES);
            r_state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (!PSEL) begin
          r_state_next = IDLE;
        end else begin
          r_cnt_next = r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_pready_next  = 1'b1;
            r_pslverr_next = r_dec.err;
            r_prdata_next  = w_rd_data;
            r_state_next   = DONE;
          end
        end
      end
      DONE: begin
        if (!PSEL) begin
          r_pready_next  = 1'b0;
          r_pslverr_next = 1'b0;
          r_prdata_next  = '0;
          r_state_next   = IDLE;
        end else if (PENABLE && r_pready) begin
          w_commit       = !r_dec.err;
          r_pready_next  = 1'b0;
          r_pslverr_next = 1'b0;
          r_prdata_next  = '0;
          r_state_next   = IDLE;
        end
      end
      default: r_state_next = IDLE;
    endcase
  end

  apb_reg_file #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_reg_file (
    .clk        (PCLK),
    .rst_n      (PRESETn),
    .i_commit   (w_commit),
    .i_idx      (r_dec.idx),
    .i_wdata    (r_wdata),
    .i_write    (r_dec.is_write),
    .i_count    (w_commit),
    .o_regs     (regs_o),
    .o_wr_pulse (wr_pulse_o)
  );

  assign PRDATA  = r_prdata;
  assign PREADY  = r_pready;
  assign PSLVERR = r_pslverr;

endmodule

// File: tb/tb_apb_slave_regs.sv
// Drives three slaves (0, 1 and 3 wait states) on a shared APB bus and checks them against a register-map model.
module tb_apb_slave_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  psel = '0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;

  logic [31:0]  prdata_a  [3];
  logic         pready_a  [3];
  logic         pslverr_a [3];
  logic [255:0] regs_a    [3];
  logic [7:0]   pulse_a   [3];

  int           sel = 0;
  logic [31:0]  prdata_s;
  logic         pready_s, pslverr_s;
  logic [255:0] regs_s;
  logic [7:0]   pulse_s;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [3][8];
  logic [31:0] cnt [3];
  logic [31:0] last_rdata;
  logic        last_err;
  int          last_waits;
  logic [7:0]  last_p1;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    apb_slave_regs #(
      .WAIT_STATES ((gi == 2) ? 3 : gi)
    ) u_dut (
      .PCLK       (clk),
      .PRESETn    (rst_n),
      .PSEL       (psel[gi]),
      .PENABLE    (penable),
      .PWRITE     (pwrite),
      .PADDR      (paddr),
      .PWDATA     (pwdata),
      .PRDATA     (prdata_a[gi]),
      .PREADY     (pready_a[gi]),
      .PSLVERR    (pslverr_a[gi]),
      .regs_o     (regs_a[gi]),
      .wr_pulse_o (pulse_a[gi])
    );
  end

  always_comb begin
    prdata_s  = prdata_a[sel];
    pready_s  = pready_a[sel];
    pslverr_s = pslverr_a[sel];
    regs_s    = regs_a[sel];
    pulse_s   = pulse_a[sel];
  end

  function automatic int ws_of(int d);
    return (d == 2) ? 3 : d;
  endfunction

  // Register map rules: word aligned, 8 registers, top one read-only.
  function automatic bit exp_err(bit wr, logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= 8) || (wr && (a / 4 == 7));
  endfunction

  function automatic logic [31:0] model_read(int d, logic [31:0] idx);
    if (idx == 7) return cnt[d];
    return mem[d][idx];
  endfunction

  function automatic logic [255:0] model_flat(int d);
    logic [255:0] f;
    for (int i = 0; i < 7; i++) f[i*32 +: 32] = mem[d][i];
    f[255:224] = cnt[d];
    return f;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      cnt[d] = '0;
      for (int i = 0; i < 8; i++) mem[d][i] = '0;
    end
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data, input bit hold);
    bit          eerr;
    logic [31:0] idx;
    logic [31:0] exp_rd;
    logic [7:0]  exp_p;
    int          waits;
    eerr   = exp_err(wr, addr);
    idx    = addr / 4;
    exp_rd = '0;
    if (!eerr && !wr) exp_rd = model_read(d, idx);
    exp_p  = (wr && !eerr) ? (8'b1 << idx) : 8'h00;
    sel = d;
    @(posedge clk); #1;
    psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    while (!pready_s && waits < 40) begin
      chk("prdata_zero_while_waiting", prdata_s, 0);
      @(posedge clk); #1;
      waits++;
    end
    chk("wait_cycles", waits, ws_of(d));
    chk("pslverr", pslverr_s, eerr);
    if (!wr || eerr) chk("prdata", prdata_s, exp_rd);
    last_rdata = prdata_s;
    last_err   = pslverr_s;
    last_waits = waits;
    @(posedge clk); #1;
    if (!hold) begin psel[d] = 1'b0; penable = 1'b0; end
    if (!eerr) begin
      if (wr) mem[d][idx] = data;
      cnt[d] = cnt[d] + 1;
    end
    last_p1 = pulse_s;
    chk("wr_pulse_after_commit", pulse_s, exp_p);
    chk("pready_low_after_commit", pready_s, 0);
    chk("regs_after_commit", regs_s, model_flat(d));
    @(posedge clk); #1;
    chk("wr_pulse_one_cycle", pulse_s, 0);
    if (hold) begin psel[d] = 1'b0; penable = 1'b0; end
    chk("regs_settled", regs_s, model_flat(d));
  endtask

  initial begin
    logic [31:0] a;
    int          d;
    bit          wr;
    int          kind;

    model_reset();
    repeat (3) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      sel = i; #1;
      chk("reset_prdata", prdata_s, 0);
      chk("reset_pready", pready_s, 0);
      chk("reset_pslverr", pslverr_s, 0);
      chk("reset_wr_pulse", pulse_s, 0);
      chk("reset_regs", regs_s, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // One wait state: write then read back register 1.
    xfer(1, 1, 32'h4, 32'hDEADBEEF, 0);
    chk("ws1_write_waits", last_waits, 1);
    chk("ws1_strobe_reg1", last_p1, 8'h02);
    chk("ws1_regs_o_slice", regs_a[1][63:32], 32'hDEADBEEF);
    xfer(1, 0, 32'h4, 32'h0, 0);
    chk("ws1_read_data", last_rdata, 32'hDEADBEEF);
    chk("ws1_read_err", last_err, 0);

    // Zero wait states: counter sequence on a fresh slave.
    xfer(0, 1, 32'h0, 32'h11111111, 0);
    xfer(0, 1, 32'h8, 32'h22222222, 0);
    xfer(0, 1, 32'hC, 32'h33333333, 0);
    xfer(0, 0, 32'h0, 32'h0, 0);
    chk("ws0_waits", last_waits, 0);
    chk("ws0_read_data", last_rdata, 32'h11111111);
    xfer(0, 0, 32'h4, 32'h0, 0);
    xfer(0, 1, 32'h2, 32'hBAD0BAD0, 0);
    chk("misaligned_err", last_err, 1);
    chk("misaligned_prdata", last_rdata, 0);
    chk("misaligned_strobe", last_p1, 0);
    xfer(0, 0, 32'h1C, 32'h0, 0);
    chk("counter_first", last_rdata, 5);
    xfer(0, 0, 32'h1C, 32'h0, 0);
    chk("counter_second", last_rdata, 6);
    xfer(0, 1, 32'h20, 32'hBAD1BAD1, 0);
    chk("range_err", last_err, 1);
    chk("range_strobe", last_p1, 0);
    xfer(0, 1, 32'h1C, 32'hBAD2BAD2, 0);
    chk("ro_err", last_err, 1);
    chk("ro_prdata", last_rdata, 0);

    // Master keeps PSEL/PENABLE up one cycle past completion.
    xfer(0, 1, 32'h10, 32'hCAFEF00D, 1);
    chk("hold_strobe", last_p1, 8'h10);
    xfer(0, 0, 32'h1C, 32'h0, 0);
    chk("hold_counter", last_rdata, 8);

    // Three wait states, then an abort during the wait phase.
    xfer(2, 1, 32'h18, 32'h0BADCAFE, 0);
    chk("ws3_write_waits", last_waits, 3);
    xfer(2, 0, 32'h18, 32'h0, 0);
    chk("ws3_read_data", last_rdata, 32'h0BADCAFE);
    sel = 2;
    @(posedge clk); #1;
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h18; pwdata = 32'h12345678;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    chk("abort_pready_before", pready_s, 0);
    psel[2] = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    chk("abort_pready", pready_s, 0);
    chk("abort_strobe", pulse_s, 0);
    chk("abort_regs", regs_s, model_flat(2));
    @(posedge clk); #1;
    chk("abort_strobe_late", pulse_s, 0);
    xfer(2, 0, 32'h18, 32'h0, 0);
    chk("abort_reg_kept", last_rdata, 32'h0BADCAFE);

    // Random mix of legal and illegal accesses across all three slaves.
    for (int n = 0; n < 45; n++) begin
      d    = $urandom_range(0, 2);
      wr   = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 9);
      if (kind < 8)       a = 32'(kind * 4);
      else if (kind == 8) a = 32'($urandom_range(0, 7) * 4 + $urandom_range(1, 3));
      else                a = 32'h20 + 32'($urandom_range(0, 64) * 4);
      xfer(d, wr, a, $urandom, 0);
    end

    // Reset asserted while the slave is presenting PREADY.
    sel = 1;
    @(posedge clk); #1;
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'h55AA55AA;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_done_pready", pready_s, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_pready", pready_s, 0);
    chk("rst_async_pslverr", pslverr_s, 0);
    chk("rst_async_prdata", prdata_s, 0);
    chk("rst_async_strobe", pulse_s, 0);
    model_reset();
    for (int i = 0; i < 3; i++) begin
      sel = i; #1;
      chk("rst_async_regs", regs_s, model_flat(i));
    end
    psel = '0; penable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    xfer(1, 0, 32'h8, 32'h0, 0);
    chk("rst_write_discarded", last_rdata, 0);
    xfer(1, 0, 32'h4, 32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
